// File: rtl/jpeg_vlc_bitpacker.sv
// JPEG scan bit packer: appends variable-length codes MSB-first into an accumulator,
// emits bytes with optional 0xFF->0xFF,0x00 stuffing and 1-padding on flush.
//
// state | meaning
// RUN   | accepting codes, emitting full bytes
// STUFF | presenting the 0x00 stuff byte after an emitted 0xFF
// FLUSH | draining remaining bits, partial byte padded with 1s
// DONE  | one-cycle flush_done pulse, then back to RUN
module jpeg_vlc_bitpacker #(
    parameter int MAX_CODE_LEN = 16,
    parameter int ACC_W        = 32,
    parameter int LEN_W        = 5,
    parameter int STUFF_EN     = 1,
    parameter int CNT_W        = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [MAX_CODE_LEN-1:0] in_code,
    input  logic [LEN_W-1:0]        in_len,
    input  logic                    in_flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_byte,
    output logic                    flush_done,
    output logic [CNT_W-1:0]        byte_cnt
);
    localparam int FILL_W = $clog2(ACC_W + 1);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_STUFF = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [FILL_W-1:0] FILL_LIMIT = FILL_W'(ACC_W - MAX_CODE_LEN);
    localparam logic [ACC_W-1:0]  TOP_MASK   = {8'hFF, {(ACC_W-8){1'b0}}};

    logic [1:0]        state, nxt_state;
    logic              ret_flush, nxt_ret;
    logic [ACC_W-1:0]  acc, nxt_acc, base_acc, code_ext;
    logic [FILL_W-1:0] fill, nxt_fill, base_fill;
    logic [FILL_W:0]   sh_up;
    logic [LEN_W-1:0]  len_c;
    logic              nxt_ov;
    logic [7:0]        nxt_ob;
    logic              accept, out_hs, flush_in, stuff_hit;

    assign in_ready   = ~rst & (state == S_RUN) & (fill <= FILL_LIMIT);
    assign flush_done = (state == S_DONE);

    assign accept    = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;
    assign flush_in  = accept & in_flush;
    assign stuff_hit = out_hs & (STUFF_EN != 0) & (out_byte == 8'hFF);

    assign len_c    = (in_len > LEN_W'(MAX_CODE_LEN)) ? LEN_W'(MAX_CODE_LEN) : in_len;
    assign code_ext = ACC_W'(in_code) & ~({ACC_W{1'b1}} << len_c);
    assign sh_up    = (FILL_W+1)'(ACC_W) - (FILL_W+1)'(len_c);

    always_comb begin
        nxt_state = state;
        nxt_ret   = ret_flush;
        base_acc  = acc;
        base_fill = fill;
        // Emitting and appending in one cycle: drop the outgoing byte first, then append.
        if (out_hs && state != S_STUFF) begin
            base_acc  = acc << 8;
            base_fill = fill - FILL_W'(8);
        end
        nxt_acc  = base_acc;
        nxt_fill = base_fill;
        if (accept) begin
            nxt_acc  = base_acc | ((code_ext << sh_up) >> base_fill);
            nxt_fill = base_fill + FILL_W'(len_c);
        end

        case (state)
            S_RUN: begin
                if (stuff_hit) begin
                    nxt_state = S_STUFF;
                    nxt_ret   = flush_in;
                end else if (flush_in) begin
                    nxt_state = (nxt_fill == '0) ? S_DONE : S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (stuff_hit) begin
                    nxt_state = S_STUFF;
                    nxt_ret   = 1'b1;
                end else if (nxt_fill == '0) begin
                    nxt_state = S_DONE;
                end
            end
            S_STUFF: begin
                if (out_hs) begin
                    if (ret_flush) nxt_state = (fill == '0) ? S_DONE : S_FLUSH;
                    else           nxt_state = S_RUN;
                end
            end
            default: nxt_state = S_RUN;
        endcase

        // Any partial tail while flushing is completed with 1s to a whole byte.
        if ((nxt_state == S_FLUSH || (nxt_state == S_STUFF && nxt_ret)) &&
            nxt_fill != '0 && nxt_fill < FILL_W'(8)) begin
            nxt_acc  = nxt_acc | ((TOP_MASK >> nxt_fill) & TOP_MASK);
            nxt_fill = FILL_W'(8);
        end

        if (nxt_state != S_FLUSH && nxt_state != S_STUFF)
            nxt_ret = 1'b0;

        nxt_ov = ((nxt_state == S_RUN || nxt_state == S_FLUSH) && nxt_fill >= FILL_W'(8)) ||
                 (nxt_state == S_STUFF);
        nxt_ob = (nxt_state == S_STUFF) ? 8'h00 : nxt_acc[ACC_W-1 -: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_RUN;
            ret_flush <= 1'b0;
            acc       <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
            out_byte  <= 8'h00;
            byte_cnt  <= '0;
        end else begin
            state     <= nxt_state;
            ret_flush <= nxt_ret;
            acc       <= nxt_acc;
            fill      <= nxt_fill;
            out_valid <= nxt_ov;
            out_byte  <= nxt_ob;
            if (out_hs)
                byte_cnt <= byte_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_jpeg_vlc_bitpacker.sv
// Directed bench for jpeg_vlc_bitpacker: one stuffing instance, one non-stuffing instance.
module tb_jpeg_vlc_bitpacker;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_valid_b = 1'b0;
    logic        in_ready, in_ready_b;
    logic [15:0] in_code = '0;
    logic [4:0]  in_len = '0;
    logic        in_flush = 1'b0;
    logic        out_valid, out_valid_b;
    logic        out_ready = 1'b0, out_ready_b = 1'b0;
    logic [7:0]  out_byte, out_byte_b;
    logic        flush_done, flush_done_b;
    logic [31:0] byte_cnt, byte_cnt_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    jpeg_vlc_bitpacker #(.STUFF_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .in_len(in_len), .in_flush(in_flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
        .flush_done(flush_done), .byte_cnt(byte_cnt)
    );

    jpeg_vlc_bitpacker #(.STUFF_EN(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_code(in_code), .in_len(in_len), .in_flush(in_flush),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_byte(out_byte_b),
        .flush_done(flush_done_b), .byte_cnt(byte_cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send(input logic [15:0] code, input logic [4:0] len, input logic fl);
        int n = 0;
        in_code  = code;
        in_len   = len;
        in_flush = fl;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_flush = 1'b0;
    endtask

    // Called at a negedge with out_ready=1; returns at the negedge after the byte is taken.
    task automatic expect_byte(input string tag, input logic [7:0] exp);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk(tag, {24'd0, out_byte}, {24'd0, exp});
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_byte", {24'd0, out_byte}, 32'h00);
        chk("rst_flush_done", {31'd0, flush_done}, 32'd0);
        chk("rst_byte_cnt", byte_cnt, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // 101 + 11111 -> 0xBF
        out_ready = 1'b1;
        send(16'b101, 5'd3, 1'b0);
        send(16'b11111, 5'd5, 1'b0);
        expect_byte("t1_byte", 8'hBF);
        chk("t1_cnt", byte_cnt, 32'd1);
        chk("t1_idle", {31'd0, out_valid}, 32'd0);

        // FF,12 with stuffing -> FF 00 12
        out_ready = 1'b0;
        send(16'h00FF, 5'd8, 1'b0);
        send(16'h0012, 5'd8, 1'b0);
        out_ready = 1'b1;
        expect_byte("t2_ff", 8'hFF);
        chk("t2_stuff_in_ready", {31'd0, in_ready}, 32'd0);
        expect_byte("t2_00", 8'h00);
        expect_byte("t2_12", 8'h12);
        chk("t2_cnt", byte_cnt, 32'd4);

        // single 0 bit flushed -> 0x7F then flush_done
        send(16'h0000, 5'd1, 1'b1);
        expect_byte("t3_7f", 8'h7F);
        chk("t3_flush_done", {31'd0, flush_done}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("t3_flush_done_off", {31'd0, flush_done}, 32'd0);
        chk("t3_idle", {31'd0, out_valid}, 32'd0);
        chk("t3_in_ready", {31'd0, in_ready}, 32'd1);

        // 7 ones flushed with stuffing -> FF 00, flush_done
        send(16'h007F, 5'd7, 1'b1);
        expect_byte("t4_ff", 8'hFF);
        expect_byte("t4_00", 8'h00);
        chk("t4_flush_done", {31'd0, flush_done}, 32'd1);
        chk("t4_cnt", byte_cnt, 32'd7);

        // same on the non-stuffing instance -> FF only
        in_code = 16'h007F; in_len = 5'd7; in_flush = 1'b1; in_valid_b = 1'b1;
        chk("t4b_in_ready", {31'd0, in_ready_b}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid_b = 1'b0; in_flush = 1'b0;
        chk("t4b_valid", {31'd0, out_valid_b}, 32'd1);
        chk("t4b_byte", {24'd0, out_byte_b}, 32'hFF);
        out_ready_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t4b_flush_done", {31'd0, flush_done_b}, 32'd1);
        chk("t4b_no_stuff", {31'd0, out_valid_b}, 32'd0);
        chk("t4b_cnt", byte_cnt_b, 32'd1);

        // backpressure: two 16-bit beats fill the accumulator
        out_ready = 1'b0;
        send(16'hA5A5, 5'd16, 1'b0);
        send(16'hA5A5, 5'd16, 1'b0);
        chk("t5_in_ready_full", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("t5_hold_byte", {24'd0, out_byte}, 32'hA5);
        out_ready = 1'b1;
        expect_byte("t5_b0", 8'hA5);
        expect_byte("t5_b1", 8'hA5);
        expect_byte("t5_b2", 8'hA5);
        expect_byte("t5_b3", 8'hA5);
        chk("t5_idle", {31'd0, out_valid}, 32'd0);
        chk("t5_cnt", byte_cnt, 32'd11);

        // clamp, zero length and masking
        send(16'h1234, 5'd31, 1'b0);
        expect_byte("clamp_hi", 8'h12);
        expect_byte("clamp_lo", 8'h34);
        send(16'hFFFF, 5'd0, 1'b0);
        send(16'hFFF0, 5'd4, 1'b0);
        send(16'hFFFF, 5'd4, 1'b0);
        expect_byte("mask_0f", 8'h0F);
        chk("mask_idle", {31'd0, out_valid}, 32'd0);

        // reset mid-stream with 12 bits buffered
        out_ready = 1'b0;
        send(16'h0ABC, 5'd12, 1'b0);
        chk("t6_pre_valid", {31'd0, out_valid}, 32'd1);
        chk("t6_pre_byte", {24'd0, out_byte}, 32'hAB);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_cnt", byte_cnt, 32'd0);
        chk("t6_rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        send(16'h003C, 5'd8, 1'b0);
        expect_byte("t6_3c", 8'h3C);
        chk("t6_idle", {31'd0, out_valid}, 32'd0);
        chk("t6_cnt", byte_cnt, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
